// File: rtl/simon_encrypt.sv
`default_nettype none
// ============================================================================
//  Module      : simon_encrypt
//  Description : Iterative SIMON block encryptor, one round per clock.
//                Supports SIMON 64/128 (44 rounds, 32-bit words) and
//                SIMON 128/128 (68 rounds, 64-bit words) from a key
//                schedule that is expanded elsewhere and presented as an
//                array of round keys.
//  Revision    : 1.0  initial release
// ============================================================================
module simon_encrypt #(
  parameter int SIMON_MAX_ROUNDS     = 68,
  parameter int SIMON_MAX_WORD_WIDTH = 64,
  parameter int SIMON_BLOCK_WIDTH    = 128
) (
  input  logic                            ck,
  input  logic                            nrst,
  input  logic                            mode,
  input  logic [SIMON_MAX_WORD_WIDTH-1:0] round_keys [0:SIMON_MAX_ROUNDS-1],
  input  logic                            keys_valid,
  input  logic [SIMON_BLOCK_WIDTH-1:0]    pt,
  input  logic                            pt_valid,
  output logic                            pt_ready,
  output logic [SIMON_BLOCK_WIDTH-1:0]    ct,
  output logic                            ct_valid,
  input  logic                            ct_ready
);

  // Last round index for each cipher; the counter stops here instead of
  // wrapping, and reaching it ends the RUN phase.
  localparam logic [6:0] c_LAST_64  = 7'd43;
  localparam logic [6:0] c_LAST_128 = 7'd67;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_mode;    // 0 = 64/128, 1 = 128/128, frozen at accept
  logic [6:0]  r_round;
  logic [63:0] r_x;       // in 64/128 only the low 32 bits are live
  logic [63:0] r_y;

  logic        w_pt_ready;
  logic        w_accept;
  logic        w_last;
  logic [63:0] w_key;
  logic [31:0] w_x32;
  logic [31:0] w_f32;
  logic [63:0] w_f64;
  logic [63:0] w_x_next;

  // Handshake flags are pure functions of the state (plus key availability).
  assign w_pt_ready = (r_state == S_IDLE) && keys_valid;
  assign w_accept   = pt_valid && w_pt_ready;
  assign pt_ready   = w_pt_ready;
  assign ct_valid   = (r_state == S_DONE);

  // Ciphertext is driven straight from the word registers, which do not
  // change in DONE, so it is stable for as long as ct_valid is held.
  assign ct = r_mode ? {r_x, r_y} : {64'b0, r_x[31:0], r_y[31:0]};

  assign w_last = (r_round == (r_mode ? c_LAST_128 : c_LAST_64));
  assign w_key  = round_keys[r_round];

  // 32-bit round function: y ^ (S1(x) & S8(x)) ^ S2(x) ^ k, low key half only.
  assign w_x32 = r_x[31:0];
  assign w_f32 = r_y[31:0]
               ^ ({w_x32[30:0], w_x32[31]} & {w_x32[23:0], w_x32[31:24]})
               ^ {w_x32[29:0], w_x32[31:30]}
               ^ w_key[31:0];

  // 64-bit round function, same structure on full-width words.
  assign w_f64 = r_y
               ^ ({r_x[62:0], r_x[63]} & {r_x[55:0], r_x[63:56]})
               ^ {r_x[61:0], r_x[63:62]}
               ^ w_key;

  assign w_x_next = r_mode ? w_f64 : {32'b0, w_f32};

  // Control FSM and datapath: accept, iterate rounds, hold result until consumed.
  always_ff @(posedge ck) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_round <= 7'd0;
      r_x     <= 64'd0;
      r_y     <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode  <= mode;
            r_round <= 7'd0;
            if (mode) begin
              r_x <= pt[127:64];
              r_y <= pt[63:0];
            end else begin
              r_x <= {32'b0, pt[63:32]};
              r_y <= {32'b0, pt[31:0]};
            end
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Losing the key schedule mid-block invalidates the block.
          if (!keys_valid) begin
            r_state <= S_IDLE;
          end else begin
            r_x <= w_x_next;
            r_y <= r_x;
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_round <= r_round + 7'd1;
            end
          end
        end
        S_DONE: begin
          if (ct_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
